multi_alignment: RTL and testbench

N-channel frame aligner for the trigger data path: each lane carries fixed-length frames that begin with a header word, and the lanes arrive with independent skews of up to DEPTH-1 cycles. The block buffers every lane, detects the header on each unmasked lane, and re-emits all lanes so that their headers leave on the same cycle. It also checks the per-lane crate ID word against the expected value and reports skew timeouts. It generalises the three-lane aligner in channel count, width, depth and frame length, and adds timeout recovery and per-lane masking.

---
 rtl/align_pkg.sv | 14 +
 rtl/align_lane.sv | 69 ++++++
 rtl/multi_alignment.sv | 185 ++++++++++++++++++
 tb/tb_multi_alignment.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/align_pkg.sv
// Shared types and defaults for the multi-lane frame aligner.
package align_pkg;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    ARMED  = 2'd1,
    STREAM = 2'd2
  } state_e;

  localparam int unsigned IDLE_WORD_DEF = 999;
  localparam logic [15:0] HEADER_DEF    = 16'hAAAA;
  localparam int unsigned ID_W          = 5;

endpackage

// File: rtl/align_lane.sv
// One aligner lane: delay line, header detect, header-age pointer and tag.
module align_lane
  import align_pkg::*;
#(
  parameter int          W      = 16,
  parameter int          DEPTH  = 64,
  parameter logic [W-1:0] HEADER = W'(HEADER_DEF)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         mask,
  input  logic         hunt,
  input  logic         armed,
  input  logic         clear,
  input  logic [W-1:0] din,
  output logic         hdr,
  output logic         tag,
  output logic [W-1:0] word
);

  localparam int PW = $clog2(DEPTH);

  logic [W-1:0]  dly_q [DEPTH];
  logic [W-1:0]  dly_d [DEPTH];
  logic [PW-1:0] ptr_q, ptr_d;
  logic          tag_q, tag_d;

  assign hdr  = hunt & ~mask & (din == HEADER);
  assign tag  = tag_q;
  assign word = dly_q[ptr_q];

  always_comb begin
    dly_d[0] = din;
    for (int i = 1; i < DEPTH; i++) dly_d[i] = dly_q[i-1];
  end

  // NOTE: the delay line has no reset; its contents are don't-care until din has shifted through.
  always_ff @(posedge clk) begin
    dly_q <= dly_d;
  end

  // The pointer is the age of this lane's latest header, so buf[ptr] holds it.
  // NOTE: defaults come first so every path assigns ptr_d/tag_d and no latch is inferred.
  always_comb begin
    ptr_d = ptr_q;
    tag_d = tag_q;
    if (clear) begin
      ptr_d = '0;
      tag_d = 1'b0;
    end else if (hdr) begin
      ptr_d = '0;
      tag_d = 1'b1;
    end else if (armed) begin
      ptr_d = ptr_q + 1'b1;
    end
  end

  // NOTE: non-blocking assignments so every flop samples pre-edge values together.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr_q <= '0;
      tag_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
      tag_q <= tag_d;
    end
  end

endmodule

// File: rtl/multi_alignment.sv
// N-lane frame aligner: lines up per-lane headers and re-emits the lanes together.
// Optional diagnostics (timeout flags, crate-ID check, err_clr) under MULTI_ALIGNMENT_DIAG_EN.
module multi_alignment
  import align_pkg::*;
#(
  parameter int           NCH       = 3,
  parameter int           W         = 16,
  parameter int           DEPTH     = 64,
  parameter logic [W-1:0] HEADER    = W'(HEADER_DEF),
  parameter int           FRAME_LEN = 20,
  parameter int           ID_IDX    = 18,
  parameter logic [W-1:0] IDLE_WORD = W'(IDLE_WORD_DEF)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NCH-1:0]      ch_mask,
  input  logic [NCH*W-1:0]    din,
  input  logic [ID_W-1:0]     base_id,
  output logic [NCH*W-1:0]    dout,
  output logic                dout_valid,
  output logic                frame_start,
  output logic [NCH*ID_W-1:0] crate_id,
  output logic [NCH-1:0]      err_timeout,
  output logic [NCH-1:0]      err_id,
  input  logic                err_clr
);

  localparam int WC_W = $clog2(DEPTH);
  localparam int FC_W = $clog2(FRAME_LEN);

  state_e          state_q, state_d;
  logic [WC_W-1:0] wc_q, wc_d;
  logic [FC_W-1:0] fc_q, fc_d;
  logic [NCH*W-1:0] dout_q, dout_d;
  logic            valid_q, valid_d;
  logic            start_q, start_d;

  logic [NCH-1:0]  hdr, tag, tag_now;
  logic [W-1:0]    lane_word [NCH];
  logic            hunt, armed, clear, timeout, all_tagged;

  assign hunt  = (state_q != STREAM);
  assign armed = (state_q == ARMED);

  for (genvar c = 0; c < NCH; c++) begin : g_lane
    align_lane #(
      .W      (W),
      .DEPTH  (DEPTH),
      .HEADER (HEADER)
    ) u_lane (
      .clk   (clk),
      .reset (reset),
      .mask  (ch_mask[c]),
      .hunt  (hunt),
      .armed (armed),
      .clear (clear),
      .din   (din[c*W +: W]),
      .hdr   (hdr[c]),
      .tag   (tag[c]),
      .word  (lane_word[c])
    );
  end

  // Masked lanes and headers arriving on this edge both count as tagged.
  assign tag_now    = tag | ch_mask | hdr;
  assign all_tagged = &tag_now;

  always_comb begin
    state_d = state_q;
    wc_d    = wc_q;
    fc_d    = fc_q;
    clear   = 1'b0;
    timeout = 1'b0;
    unique case (state_q)
      SEARCH: begin
        wc_d = '0;
        fc_d = '0;
        if (|hdr) state_d = all_tagged ? STREAM : ARMED;
      end
      ARMED: begin
        wc_d = wc_q + 1'b1;
        if (all_tagged) begin
          state_d = STREAM;
          wc_d    = '0;
        end else if (wc_q == WC_W'(DEPTH-2)) begin
          state_d = SEARCH;
          wc_d    = '0;
          clear   = 1'b1;
          timeout = 1'b1;
        end
      end
      STREAM: begin
        fc_d = fc_q + 1'b1;
        if (fc_q == FC_W'(FRAME_LEN-1)) begin
          state_d = SEARCH;
          fc_d    = '0;
          clear   = 1'b1;
        end
      end
      default: begin
        state_d = SEARCH;
        clear   = 1'b1;
      end
    endcase
  end

  always_comb begin
    for (int c = 0; c < NCH; c++) begin
      dout_d[c*W +: W] = ch_mask[c]           ? '0 :
                         (state_q == STREAM)  ? lane_word[c] : IDLE_WORD;
    end
    valid_d = (state_q == STREAM);
    start_d = (state_q == STREAM) && (fc_q == '0);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= SEARCH;
      wc_q    <= '0;
      fc_q    <= '0;
      dout_q  <= {NCH{IDLE_WORD}};
      valid_q <= 1'b0;
      start_q <= 1'b0;
    end else begin
      state_q <= state_d;
      wc_q    <= wc_d;
      fc_q    <= fc_d;
      dout_q  <= dout_d;
      valid_q <= valid_d;
      start_q <= start_d;
    end
  end

  assign dout        = dout_q;
  assign dout_valid  = valid_q;
  assign frame_start = start_q;

`ifdef MULTI_ALIGNMENT_DIAG_EN
  logic [NCH*ID_W-1:0] crate_q, crate_d;
  logic [NCH-1:0]      tmo_q, tmo_d;
  logic [NCH-1:0]      eid_q, eid_d;

  // Clear is applied first so a same-cycle error still sets its flag.
  always_comb begin
    crate_d = crate_q;
    tmo_d   = err_clr ? '0 : tmo_q;
    eid_d   = err_clr ? '0 : eid_q;
    if (timeout) tmo_d = tmo_d | ~tag_now;
    if (state_q == STREAM && fc_q == FC_W'(ID_IDX)) begin
      for (int c = 0; c < NCH; c++) begin
        crate_d[c*ID_W +: ID_W] = ch_mask[c] ? '0 : lane_word[c][ID_W-1:0];
        if (!ch_mask[c] && (lane_word[c][ID_W-1:0] != (base_id + ID_W'(c))))
          eid_d[c] = 1'b1;
      end
    end else if (state_q == STREAM && fc_q == FC_W'(FRAME_LEN-1)) begin
      crate_d = '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      crate_q <= '0;
      tmo_q   <= '0;
      eid_q   <= '0;
    end else begin
      crate_q <= crate_d;
      tmo_q   <= tmo_d;
      eid_q   <= eid_d;
    end
  end

  assign crate_id    = crate_q;
  assign err_timeout = tmo_q;
  assign err_id      = eid_q;
`else
  localparam int unused_id_idx = ID_IDX;
  logic unused_diag;
  assign unused_diag = ^{err_clr, base_id, timeout};

  assign crate_id    = '0;
  assign err_timeout = '0;
  assign err_id      = '0;
`endif

endmodule

// File: tb/tb_multi_alignment.sv
// Directed bench for multi_alignment: skew, window limits, masking, crate ID, repeat header, reset.
module tb_multi_alignment;

  localparam int NCH = 3;
  localparam int W = 16;
  localparam int DEPTH = 64;
  localparam int FRAME_LEN = 20;
  localparam int ID_IDX = 18;
  localparam logic [W-1:0] HDR  = 16'hAAAA;
  localparam logic [W-1:0] IDLE = 16'd999;
  localparam logic [W-1:0] FILL = 16'h0055;
`ifdef MULTI_ALIGNMENT_DIAG_EN
  localparam bit DIAG = 1'b1;
`else
  localparam bit DIAG = 1'b0;
`endif

  logic               clk = 1'b0;
  logic               reset;
  logic [NCH-1:0]     ch_mask;
  logic [NCH*W-1:0]   din;
  logic [4:0]         base_id;
  logic [NCH*W-1:0]   dout;
  logic               dout_valid;
  logic               frame_start;
  logic [NCH*5-1:0]   crate_id;
  logic [NCH-1:0]     err_timeout;
  logic [NCH-1:0]     err_id;
  logic               err_clr;

  always #5 clk = ~clk;

  multi_alignment #(
    .NCH(NCH), .W(W), .DEPTH(DEPTH), .HEADER(HDR),
    .FRAME_LEN(FRAME_LEN), .ID_IDX(ID_IDX), .IDLE_WORD(IDLE)
  ) dut (
    .clk(clk), .reset(reset), .ch_mask(ch_mask), .din(din), .base_id(base_id),
    .dout(dout), .dout_valid(dout_valid), .frame_start(frame_start),
    .crate_id(crate_id), .err_timeout(err_timeout), .err_id(err_id), .err_clr(err_clr)
  );

  int n_tests = 0;
  int n_fail  = 0;

  int         hdr_t [NCH];
  int         stray_t;
  logic [4:0] id_v  [NCH];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [W-1:0] gen(input int c, input int j, input logic [4:0] id);
    if (j == 0) return HDR;
    if (j == ID_IDX) return {{(W-5){1'b0}}, id};
    return W'((c + 1) * 4096 + j);
  endfunction

  function automatic logic [NCH*W-1:0] idle_vec();
    logic [NCH*W-1:0] v;
    for (int c = 0; c < NCH; c++) v[c*W +: W] = ch_mask[c] ? '0 : IDLE;
    return v;
  endfunction

  // Drives one scheduled frame per lane and checks the aligned output cycle by cycle.
  task automatic run_frame(input string name, input int ncyc, input bit exp_frame, input int rst_j);
    int last_h  = -1;
    int fs_cnt  = 0;
    int fs_at   = -1;
    int v_cnt   = 0;
    int j       = -1;
    bit rst_hit = 1'b0;
    logic [NCH*W-1:0] exp_v;
    logic [NCH*5-1:0] exp_id;
    for (int c = 0; c < NCH; c++)
      if (!ch_mask[c] && hdr_t[c] > last_h) last_h = hdr_t[c];
    for (int t = 0; t < ncyc; t++) begin
      for (int c = 0; c < NCH; c++) begin
        logic [W-1:0] w;
        w = FILL;
        if (hdr_t[c] >= 0 && t >= hdr_t[c] && t < hdr_t[c] + FRAME_LEN)
          w = gen(c, t - hdr_t[c], id_v[c]);
        else if (c == 0 && t == stray_t)
          w = HDR;
        din[c*W +: W] = w;
      end
      tick();
      if (frame_start) begin
        fs_cnt++;
        if (fs_at < 0) fs_at = t;
        j = 0;
      end else if (j >= 0) begin
        j++;
      end
      if (dout_valid) begin
        v_cnt++;
        for (int c = 0; c < NCH; c++) exp_v[c*W +: W] = ch_mask[c] ? '0 : gen(c, j, id_v[c]);
        check({name, "_dout"}, 64'(dout), 64'(exp_v));
        if (j == ID_IDX) begin
          for (int c = 0; c < NCH; c++) exp_id[c*5 +: 5] = (ch_mask[c] || !DIAG) ? 5'd0 : id_v[c];
          check({name, "_crate_id"}, 64'(crate_id), 64'(exp_id));
        end
        if (rst_j >= 0 && j == rst_j) begin
          reset = 1'b0;
          #1;
          check({name, "_rst_dout"}, 64'(dout), 64'(idle_vec()));
          check({name, "_rst_valid"}, 64'(dout_valid), 64'd0);
          check({name, "_rst_err"}, 64'({err_timeout, err_id}), 64'd0);
          #2 reset = 1'b1;
          rst_hit = 1'b1;
          break;
        end
      end
    end
    din = {NCH{FILL}};
    if (rst_j >= 0) begin
      check({name, "_rst_reached"}, 64'(rst_hit), 64'd1);
    end else begin
      check({name, "_fs_count"}, 64'(fs_cnt), exp_frame ? 64'd1 : 64'd0);
      check({name, "_valid_len"}, 64'(v_cnt), exp_frame ? 64'(FRAME_LEN) : 64'd0);
      if (exp_frame) check({name, "_fs_time"}, 64'(fs_at), 64'(last_h + 1));
      check({name, "_idle_after"}, 64'(dout), 64'(idle_vec()));
    end
  endtask

  task automatic set_frame(input int h0, input int h1, input int h2,
                           input logic [4:0] i0, input logic [4:0] i1, input logic [4:0] i2);
    hdr_t[0] = h0; hdr_t[1] = h1; hdr_t[2] = h2;
    id_v[0]  = i0; id_v[1]  = i1; id_v[2]  = i2;
    stray_t  = -1;
  endtask

  task automatic pulse_clr();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
  endtask

  initial begin
    reset   = 1'b0;
    ch_mask = '0;
    din     = {NCH{FILL}};
    base_id = 5'd0;
    err_clr = 1'b0;
    repeat (3) tick();
    check("reset_dout", 64'(dout), 64'({NCH{IDLE}}));
    check("reset_valid", 64'(dout_valid), 64'd0);
    check("reset_fs", 64'(frame_start), 64'd0);
    check("reset_crate", 64'(crate_id), 64'd0);
    check("reset_err", 64'({err_timeout, err_id}), 64'd0);
    reset = 1'b1;
    tick();

    // Basic skew 10/15/22.
    set_frame(10, 15, 22, 5'd0, 5'd1, 5'd2);
    run_frame("basic", 46, 1'b1, -1);
    check("basic_err", 64'({err_timeout, err_id}), 64'd0);

    // Largest tolerated skew: lane 2 63 cycles after lane 0.
    set_frame(5, 5, 68, 5'd0, 5'd1, 5'd2);
    run_frame("maxskew", 93, 1'b1, -1);
    check("maxskew_err", 64'({err_timeout, err_id}), 64'd0);

    // Lane 2 still silent when the window closes: timeout, no frame.
    set_frame(5, 5, -1, 5'd0, 5'd1, 5'd2);
    run_frame("timeout", 69, 1'b0, -1);
    check("timeout_flag", 64'(err_timeout), DIAG ? 64'b100 : 64'd0);
    check("timeout_id", 64'(err_id), 64'd0);
    pulse_clr();
    check("timeout_clr", 64'(err_timeout), 64'd0);

    // Lane 2 masked and silent.
    ch_mask = 3'b100;
    tick();
    check("mask_idle", 64'(dout), 64'({16'h0000, IDLE, IDLE}));
    set_frame(10, 12, -1, 5'd0, 5'd1, 5'd9);
    run_frame("mask", 36, 1'b1, -1);
    check("mask_err", 64'({err_timeout, err_id}), 64'd0);
    ch_mask = 3'b000;
    tick();

    // Crate ID mismatch on lane 2, then cleared.
    base_id = 5'd5;
    set_frame(3, 4, 5, 5'd5, 5'd6, 5'd9);
    run_frame("crate5", 29, 1'b1, -1);
    check("crate5_err", 64'(err_id), DIAG ? 64'b100 : 64'd0);
    pulse_clr();
    check("crate5_clr", 64'(err_id), 64'd0);

    // Crate ID wrap: 31, 0, 1.
    base_id = 5'd31;
    set_frame(4, 3, 3, 5'd31, 5'd0, 5'd1);
    run_frame("crate31", 28, 1'b1, -1);
    check("crate31_err", 64'(err_id), 64'd0);

    // Repeat header on lane 0: the later one wins.
    base_id = 5'd0;
    set_frame(12, 14, 16, 5'd0, 5'd1, 5'd2);
    stray_t = 10;
    run_frame("repeat", 40, 1'b1, -1);

    // Reset mid-frame, then a clean frame.
    set_frame(2, 3, 4, 5'd0, 5'd1, 5'd2);
    run_frame("midrst", 40, 1'b1, 7);
    tick();
    set_frame(6, 8, 7, 5'd0, 5'd1, 5'd2);
    run_frame("afterrst", 32, 1'b1, -1);
    check("afterrst_err", 64'({err_timeout, err_id}), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
